// File: rtl/blinkled_seq_master_pkg.sv
// Shared types and helpers for the LED sequencer master.
// Mode encodings, FSM states and the next-pattern function.
package blinkled_seq_pkg;

    localparam logic [1:0] MODE_ROL = 2'd0;
    localparam logic [1:0] MODE_ROR = 2'd1;
    localparam logic [1:0] MODE_TOG = 2'd2;
    localparam logic [1:0] MODE_CNT = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    // Operates on a w-bit value carried in 32 bits; result is masked to w.
    function automatic logic [31:0] next_pattern(
        input logic [1:0]  mode,
        input logic [31:0] cur,
        input int unsigned w
    );
        logic [31:0] mask;
        logic [31:0] nxt;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        nxt  = '0;
        unique case (mode)
            MODE_ROL: nxt = (cur == 32'd0) ? 32'd1
                          : ((cur << 1) | (cur >> (w - 1)));
            MODE_ROR: nxt = (cur == 32'd0) ? (32'd1 << (w - 1))
                          : ((cur >> 1) | (cur << (w - 1)));
            MODE_TOG: nxt = ~cur;
            MODE_CNT: nxt = cur + 32'd1;
        endcase
        return nxt & mask;
    endfunction

endpackage

// File: rtl/blinkled_seq_master_if.sv
// Avalon-MM bus between the sequencer master and the LED PIO.
// Zero wait-state capable; waitrequest stalls the master.
interface blinkled_seq_master_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, chipselect, write, read, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, chipselect, write, read, writedata,
        output readdata, waitrequest
    );

endinterface

// File: rtl/blinkled_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, else holds 0.
// tick is high for the single cycle the count sits at TICK_DIV-1.
module blinkled_tick_gen #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/blinkled_seq_master.sv
// Avalon-MM master that steps an LED pattern into a PIO register,
// reads it back and tracks readback mismatches.
module blinkled_seq_master
    import blinkled_seq_pkg::*;
#(
    parameter int unsigned LED_W    = 6,
    parameter int unsigned TICK_DIV = 50000000,
    parameter logic [1:0]  PIO_ADDR = 2'd0,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic                 step,
    blinkled_seq_master_if.master avm,
    output logic [LED_W-1:0]     pattern,
    output logic                 busy,
    output logic                 mismatch,
    output logic [ERR_W-1:0]     err_count
);

    state_t      state;
    logic        pending;
    logic        tick;
    logic        req;
    logic [31:0] nxt;
    logic        unused_rd;

    blinkled_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign req       = tick | step;
    assign nxt       = next_pattern(mode, 32'(pattern), LED_W);
    assign unused_rd = ^avm.readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pattern        <= '0;
            pending        <= 1'b0;
            busy           <= 1'b0;
            mismatch       <= 1'b0;
            err_count      <= '0;
            avm.address    <= '0;
            avm.chipselect <= 1'b0;
            avm.write      <= 1'b0;
            avm.read       <= 1'b0;
            avm.writedata  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req || pending) begin
                        pattern        <= nxt[LED_W-1:0];
                        pending        <= 1'b0;
                        busy           <= 1'b1;
                        avm.address    <= PIO_ADDR;
                        avm.chipselect <= 1'b1;
                        avm.write      <= 1'b1;
                        avm.writedata  <= nxt;
                        state          <= WR;
                    end
                end
                WR: begin
                    if (req) pending <= 1'b1;
                    if (!avm.waitrequest) begin
                        avm.write <= 1'b0;
                        avm.read  <= 1'b1;
                        state     <= RD;
                    end
                end
                RD: begin
                    if (req) pending <= 1'b1;
                    if (!avm.waitrequest) begin
                        avm.read       <= 1'b0;
                        avm.chipselect <= 1'b0;
                        busy           <= 1'b0;
                        state          <= IDLE;
                        // Only the PIO's implemented bits take part.
                        if (avm.readdata[LED_W-1:0] != pattern) begin
                            mismatch <= 1'b1;
                            if (err_count != '1)
                                err_count <= err_count + ERR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blinkled_seq_master.sv
// Directed bench for blinkled_seq_master with a behavioural LED PIO
// slave that supports programmable wait states and corrupt readback.
module tb_blinkled_seq_master;

    localparam int unsigned LED_W    = 6;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned ERR_W    = 8;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [1:0]       mode;
    logic             step;
    logic [LED_W-1:0] pattern;
    logic             busy;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;

    blinkled_seq_master_if bus ();

    blinkled_seq_master #(
        .LED_W    (LED_W),
        .TICK_DIV (TICK_DIV),
        .PIO_ADDR (2'd0),
        .ERR_W    (ERR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .step      (step),
        .avm       (bus),
        .pattern   (pattern),
        .busy      (busy),
        .mismatch  (mismatch),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int wr_wait = 0;
    int rd_wait = 0;
    logic corrupt = 1'b0;
    logic hold_chk_en = 1'b0;

    int wcnt = 0;
    int rcnt = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int busy_cnt = 0;
    int hold_viol = 0;
    int both_viol = 0;
    logic [LED_W-1:0] pio_reg = '0;
    logic [LED_W-1:0] wr_q[$];
    int wr_cyc_q[$];
    int rd_cyc_q[$];

    logic        prev_wait_w = 1'b0;
    logic        prev_wait_r = 1'b0;
    logic [31:0] prev_wd = '0;
    logic [1:0]  prev_addr = '0;

    assign bus.waitrequest = (bus.write && (wcnt < wr_wait))
                          || (bus.read && (rcnt < rd_wait));
    assign bus.readdata = corrupt ? 32'h0 : {26'h0, pio_reg};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.write && bus.waitrequest) wcnt <= wcnt + 1;
        else wcnt <= 0;
        if (bus.read && bus.waitrequest) rcnt <= rcnt + 1;
        else rcnt <= 0;
        if (bus.chipselect && bus.write && !bus.waitrequest) begin
            pio_reg <= bus.writedata[LED_W-1:0];
            wr_cnt  <= wr_cnt + 1;
            wr_q.push_back(bus.writedata[LED_W-1:0]);
            wr_cyc_q.push_back(cyc);
        end
        if (bus.chipselect && bus.read && !bus.waitrequest) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc_q.push_back(cyc);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (bus.write && bus.read) both_viol <= both_viol + 1;
        if (hold_chk_en && prev_wait_w &&
            (!bus.write || !bus.chipselect ||
             bus.writedata != prev_wd || bus.address != prev_addr))
            hold_viol <= hold_viol + 1;
        if (hold_chk_en && prev_wait_r &&
            (!bus.read || !bus.chipselect || bus.address != prev_addr))
            hold_viol <= hold_viol + 1;
        prev_wait_w <= bus.write && bus.waitrequest;
        prev_wait_r <= bus.read && bus.waitrequest;
        prev_wd     <= bus.writedata;
        prev_addr   <= bus.address;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_step(input string tag, input logic [LED_W-1:0] exp);
        pulse();
        chk({tag, "_wr"}, {31'd0, bus.write}, 32'd1);
        chk({tag, "_wd"}, bus.writedata, 32'(exp));
        wait_idle({tag, "_idle"});
        chk({tag, "_pat"}, 32'(pattern), 32'(exp));
    endtask

    int base;
    int rbase;
    int w0;
    int r0;
    int b0;
    logic [LED_W-1:0] rol_exp [7];

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 2'd0;
        step   = 1'b0;
        rol_exp = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        repeat (3) @(negedge clk);

        chk("rst_pattern", 32'(pattern), 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_write", {31'd0, bus.write}, 32'd0);
        chk("rst_read", {31'd0, bus.read}, 32'd0);
        chk("rst_cs", {31'd0, bus.chipselect}, 32'd0);
        chk("rst_wdata", bus.writedata, 32'h0);
        chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);

        // Free-running ROL: tick every 4 cycles, seven steps.
        base  = wr_q.size();
        rbase = rd_cyc_q.size();
        reset  = 1'b0;
        enable = 1'b1;
        mode   = 2'd0;
        repeat (28) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        chk("rol_nwr", 32'(wr_q.size() - base), 32'd7);
        chk("rol_nrd", 32'(rd_cyc_q.size() - rbase), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("rol_val%0d", i), 32'(wr_q[base+i]),
                32'(rol_exp[i]));
            chk($sformatf("rol_rdgap%0d", i),
                32'(rd_cyc_q[rbase+i] - wr_cyc_q[base+i]), 32'd1);
        end
        for (int i = 1; i < 7; i++)
            chk($sformatf("rol_period%0d", i),
                32'(wr_cyc_q[base+i] - wr_cyc_q[base+i-1]), 32'd4);
        chk("rol_mismatch", {31'd0, mismatch}, 32'd0);
        chk("rol_prescaler_idle", 32'(wr_q.size() - base), 32'd7);

        // Toggle and count, including the count wrap.
        mode = 2'd2;
        do_step("tog0", 6'h3E);
        mode = 2'd3;
        do_step("cnt0", 6'h3F);
        do_step("cnt1", 6'h00);
        mode = 2'd2;
        do_step("tog1", 6'h3F);
        do_step("tog2", 6'h00);

        // Wait states: 3 on the write, 2 on the read.
        mode        = 2'd0;
        wr_wait     = 3;
        rd_wait     = 2;
        hold_chk_en = 1'b1;
        w0 = wr_cnt;
        r0 = rd_cnt;
        b0 = busy_cnt;
        do_step("ws", 6'h01);
        @(negedge clk);
        hold_chk_en = 1'b0;
        wr_wait = 0;
        rd_wait = 0;
        chk("ws_nwr", 32'(wr_cnt - w0), 32'd1);
        chk("ws_nrd", 32'(rd_cnt - r0), 32'd1);
        chk("ws_busy", 32'(busy_cnt - b0), 32'd7);
        chk("ws_hold", 32'(hold_viol), 32'd0);

        // Readback corruption and saturating error count.
        do_step("mm0", 6'h02);
        chk("mm0_flag", {31'd0, mismatch}, 32'd0);
        corrupt = 1'b1;
        do_step("mm1", 6'h04);
        chk("mm1_flag", {31'd0, mismatch}, 32'd1);
        chk("mm1_err", 32'(err_count), 32'd1);
        for (int i = 0; i < 253; i++) begin
            pulse();
            wait_idle("sat_idle");
        end
        chk("sat_254", 32'(err_count), 32'd254);
        pulse();
        wait_idle("sat_idle");
        chk("sat_255", 32'(err_count), 32'd255);
        for (int i = 0; i < 45; i++) begin
            pulse();
            wait_idle("sat_idle");
        end
        chk("sat_300", 32'(err_count), 32'd255);
        chk("sat_flag", {31'd0, mismatch}, 32'd1);
        corrupt = 1'b0;

        reset = 1'b1;
        @(negedge clk);
        chk("rst2_err", 32'(err_count), 32'd0);
        chk("rst2_mismatch", {31'd0, mismatch}, 32'd0);
        chk("rst2_pattern", 32'(pattern), 32'h0);
        reset = 1'b0;

        // Back-to-back steps: second pends, third is dropped.
        mode = 2'd1;
        base = wr_q.size();
        w0 = wr_cnt;
        r0 = rd_cnt;
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (10) @(negedge clk);
        chk("pend_nwr", 32'(wr_cnt - w0), 32'd2);
        chk("pend_nrd", 32'(rd_cnt - r0), 32'd2);
        chk("pend_val0", 32'(wr_q[base]), 32'h20);
        chk("pend_val1", 32'(wr_q[base+1]), 32'h10);
        chk("pend_pat", 32'(pattern), 32'h10);
        chk("pend_busy", {31'd0, busy}, 32'd0);

        // Reset while a write is stalled.
        mode    = 2'd0;
        wr_wait = 100;
        pulse();
        chk("rstx_wr", {31'd0, bus.write}, 32'd1);
        chk("rstx_wait", {31'd0, bus.waitrequest}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstx_write", {31'd0, bus.write}, 32'd0);
        chk("rstx_read", {31'd0, bus.read}, 32'd0);
        chk("rstx_cs", {31'd0, bus.chipselect}, 32'd0);
        chk("rstx_pattern", 32'(pattern), 32'h0);
        chk("rstx_busy", {31'd0, busy}, 32'd0);
        reset   = 1'b0;
        wr_wait = 0;
        w0 = wr_cnt;
        repeat (10) @(negedge clk);
        chk("rstx_quiet", 32'(wr_cnt - w0), 32'd0);
        chk("rstx_idle", {31'd0, busy}, 32'd0);
        chk("never_both", 32'(both_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
